// File: rtl/abs_arb_pkg.sv
// Shared types and helpers for the round-robin burst arbiter in front of the shared abs layer.
package abs_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Index width that stays at least one bit wide, so counters still exist when BURST_LEN is 1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: returns the first request at or after start_i,
// wrapping modulo NUM_CH, while skipping any channel set in excl_i.
module rr_priority_picker
    import abs_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IW     = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [NUM_CH-1:0] excl_i,
    input  logic [IW-1:0]     start_i,
    output logic              found_o,
    output logic [IW-1:0]     idx_o
);

    always_comb begin
        int c;
        c       = 0;
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = (int'(start_i) + i) % NUM_CH;
            if (!found_o && req_i[c] && !excl_i[c]) begin
                found_o = 1'b1;
                idx_o   = IW'(c);
            end
        end
    end

endmodule

// File: rtl/abs_layer_arbiter.sv
// Round-robin burst arbiter: each producer owns the shared layer for BURST_LEN words,
// forwarded through one helpful output register tagged with channel and end-of-burst.
module abs_layer_arbiter
    import abs_arb_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int NUM_CH    = 4,
    parameter int BURST_LEN = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [NUM_CH-1:0]           valid_i,
    output logic [NUM_CH-1:0]           ready_o,
    input  logic [NUM_CH*WORD_SIZE-1:0] data_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [WORD_SIZE-1:0]        data_r_o,
    output logic [$clog2(NUM_CH)-1:0]   ch_r_o,
    output logic                        last_r_o
);

    localparam int             IW       = idx_width(NUM_CH);
    localparam int             CW       = idx_width(BURST_LEN);
    localparam logic [CW-1:0]  CNT_LAST = CW'(BURST_LEN - 1);
    localparam logic [IW-1:0]  CH_LAST  = IW'(NUM_CH - 1);

    arb_state_e          state_q, state_d;
    logic [IW-1:0]       gnt_q, gnt_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic [IW-1:0]       ch_q, ch_d;
    logic                last_q, last_d;

    logic                 accept;
    logic                 xfer;
    logic                 last_beat;
    logic [IW-1:0]        gnt_next;
    logic [WORD_SIZE-1:0] sel_data;
    logic                 sel_valid;
    logic [NUM_CH-1:0]    pick_excl;
    logic [IW-1:0]        pick_start;
    logic                 pick_found;
    logic [IW-1:0]        pick_idx;

    assign accept     = ~valid_q | ready_i;
    assign gnt_next   = (gnt_q == CH_LAST) ? '0 : gnt_q + IW'(1);
    assign pick_start = (state_q == BURST) ? gnt_next : ptr_q;
    assign xfer       = (state_q == BURST) & accept & sel_valid;
    assign last_beat  = xfer & (cnt_q == CNT_LAST);

    // Steer the granted channel's data/valid in and its ready out; the finishing
    // channel is masked from the handoff search so every other requester gets a turn.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        ready_o   = '0;
        pick_excl = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (gnt_q == IW'(c)) begin
                sel_data     = data_i[c*WORD_SIZE +: WORD_SIZE];
                sel_valid    = valid_i[c];
                ready_o[c]   = (state_q == BURST) & accept;
                pick_excl[c] = (state_q == BURST);
            end
        end
    end

    rr_priority_picker #(
        .NUM_CH (NUM_CH),
        .IW     (IW)
    ) u_picker (
        .req_i   (valid_i),
        .excl_i  (pick_excl),
        .start_i (pick_start),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        ch_d    = ch_q;
        last_d  = last_q;

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        if (xfer) begin
            data_d  = sel_data;
            ch_d    = gnt_q;
            last_d  = (cnt_q == CNT_LAST);
            valid_d = 1'b1;
            cnt_d   = cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BURST;
                    gnt_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (last_beat) begin
                    ptr_d = gnt_next;
                    cnt_d = '0;
                    if (pick_found) begin
                        gnt_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
        end
    end

    assign valid_o  = valid_q;
    assign data_r_o = data_q;
    assign ch_r_o   = ch_q;
    assign last_r_o = last_q;

endmodule

// File: tb/tb_abs_layer_arbiter.sv
// Randomized bench for abs_layer_arbiter against a cycle-level transaction model of the
// burst round-robin rules (grant owner, beat count, pointer, output register contents).
module tb_abs_layer_arbiter;

    localparam int N = 4;
    localparam int L = 8;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset_i;
    logic [N-1:0]   valid_i;
    logic [N-1:0]   ready_o;
    logic [N*W-1:0] data_i;
    logic           valid_o;
    logic           ready_i;
    logic [W-1:0]   data_r_o;
    logic [1:0]     ch_r_o;
    logic           last_r_o;

    int pass_count  = 0;
    int check_count = 0;

    // Reference model state
    bit         m_busy;
    int         m_gnt;
    int         m_cnt;
    int         m_ptr;
    bit         m_ov;
    logic [W-1:0] m_data;
    int         m_ch;
    bit         m_last;
    int         seq [N];

    always #5 clk = ~clk;

    abs_layer_arbiter #(
        .WORD_SIZE (W),
        .NUM_CH    (N),
        .BURST_LEN (L)
    ) dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data_i   (data_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .data_r_o (data_r_o),
        .ch_r_o   (ch_r_o),
        .last_r_o (last_r_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // First requester at or after start (mod N), skipping channel excl (-1 for none).
    function automatic int pick(input logic [N-1:0] req, input int start, input int excl);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (start + k) % N;
            if (req[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_gnt  = 0;
        m_cnt  = 0;
        m_ptr  = 0;
        m_ov   = 0;
        m_data = '0;
        m_ch   = 0;
        m_last = 0;
    endtask

    function automatic logic [W-1:0] word_of(input int c);
        return W'((c << 12) | (seq[c] & 'hfff));
    endfunction

    // Compare DUT against the model for the current cycle, then advance the model by one clock.
    task automatic model_cycle();
        bit         accept;
        bit         xfer;
        logic [N-1:0] exp_ready;
        int         w;
        accept    = !m_ov || ready_i;
        exp_ready = (m_busy && accept) ? N'(1 << m_gnt) : '0;
        checkOutput("ready_o",  32'(ready_o),  32'(exp_ready));
        checkOutput("valid_o",  32'(valid_o),  32'(m_ov));
        checkOutput("data_r_o", 32'(data_r_o), 32'(m_data));
        checkOutput("ch_r_o",   32'(ch_r_o),   32'(m_ch));
        checkOutput("last_r_o", 32'(last_r_o), 32'(m_last));

        xfer = m_busy && accept && valid_i[m_gnt];
        if (m_ov && ready_i) m_ov = 0;
        if (xfer) begin
            m_data = data_i[m_gnt*W +: W];
            m_ch   = m_gnt;
            m_last = (m_cnt == L - 1);
            m_ov   = 1;
            seq[m_gnt]++;
            if (m_cnt == L - 1) begin
                m_ptr = (m_gnt + 1) % N;
                w     = pick(valid_i, m_ptr, m_gnt);
                m_cnt = 0;
                if (w >= 0) m_gnt = w;
                else        m_busy = 0;
            end else begin
                m_cnt++;
            end
        end else if (!m_busy) begin
            w = pick(valid_i, m_ptr, -1);
            if (w >= 0) begin
                m_busy = 1;
                m_gnt  = w;
                m_cnt  = 0;
            end
        end
    endtask

    // ready_mode: 0 = always ready, 1 = toggle every cycle, 2 = random
    task automatic applyStimulus(input int cycles, input logic [N-1:0] mask,
                                 input int pct, input int ready_mode);
        for (int k = 0; k < cycles; k++) begin
            for (int c = 0; c < N; c++) begin
                valid_i[c]       = mask[c] && ($urandom_range(99) < pct);
                data_i[c*W +: W] = word_of(c);
            end
            case (ready_mode)
                0:       ready_i = 1'b1;
                1:       ready_i = ~ready_i;
                default: ready_i = 1'($urandom_range(1));
            endcase
            @(negedge clk);
            model_cycle();
            @(posedge clk);
            #1;
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for a clock.
    task automatic do_reset();
        #2 reset_i = 1'b1;
        #1;
        checkOutput("rst_valid_o",  32'(valid_o),  32'h0);
        checkOutput("rst_ready_o",  32'(ready_o),  32'h0);
        checkOutput("rst_data_r_o", 32'(data_r_o), 32'h0);
        checkOutput("rst_ch_r_o",   32'(ch_r_o),   32'h0);
        checkOutput("rst_last_r_o", 32'(last_r_o), 32'h0);
        valid_i = '1;
        ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput("rst_held_ready_o", 32'(ready_o), 32'h0);
        end
        valid_i = '0;
        reset_i = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_i = 1'b1;
        valid_i = '0;
        data_i  = '0;
        ready_i = 1'b1;
        for (int c = 0; c < N; c++) seq[c] = 1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("init_valid_o",  32'(valid_o),  32'h0);
        checkOutput("init_ready_o",  32'(ready_o),  32'h0);
        checkOutput("init_data_r_o", 32'(data_r_o), 32'h0);
        checkOutput("init_last_r_o", 32'(last_r_o), 32'h0);
        reset_i = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] single requester on channel 2");
        applyStimulus(9, 4'b0100, 100, 0);
        applyStimulus(4, 4'b0000, 0, 0);

        $display("[TB] all channels requesting, full throughput");
        applyStimulus(40, 4'b1111, 100, 0);

        $display("[TB] all channels requesting, ready toggling");
        applyStimulus(40, 4'b1111, 100, 1);
        applyStimulus(6, 4'b0000, 0, 0);

        $display("[TB] mid-burst gap on channel 1 while channel 0 waits");
        applyStimulus(4, 4'b0010, 100, 0);
        applyStimulus(5, 4'b0001, 100, 0);
        applyStimulus(20, 4'b0011, 100, 0);
        applyStimulus(6, 4'b0000, 0, 0);

        $display("[TB] reset after a partial burst, then channel 3");
        applyStimulus(5, 4'b0010, 100, 0);
        do_reset();
        applyStimulus(12, 4'b1000, 100, 0);
        applyStimulus(4, 4'b0000, 0, 0);

        $display("[TB] random traffic with random backpressure");
        applyStimulus(400, 4'b1111, 60, 2);
        applyStimulus(200, 4'b1111, 90, 2);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
